// File: rtl/wys_lut_pkg.sv
// Shared constants and FSM encoding for the runtime-reloadable LUT bank.
package wys_lut_pkg;
  localparam int          CFG_BEATS  = 4;
  localparam int          CFG_BEAT_W = 16;
  localparam logic [63:0] MASK_XOR6  = 64'h6996966996696996;
  localparam logic [63:0] MASK_EQ3   = 64'h8040201008040201;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWAP} cfg_state_e;
endpackage

// File: rtl/wys_lut_lane.sv
// One LUT lane: shadow/active mask pair, registered 64:1 lookup, optional output stage.
module wys_lut_lane
  import wys_lut_pkg::*;
#(
  parameter logic [63:0] INIT_MASK = MASK_XOR6,
  parameter int          OUT_REG   = 1,
  parameter bit          CHIP_OK   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_sclr,
  input  logic        i_din_valid,
  input  logic        i_vld_s1,
  input  logic [5:0]  i_addr,
  input  logic        i_shadow_we,
  input  logic [63:0] i_shadow_data,
  input  logic        i_swap,
  output logic        o_dout
);
  logic [63:0] r_shadow;
  logic [63:0] r_active;
  logic        r_look;
  logic        w_dout;

  // Lookup reads the pre-swap active mask, so the swap-cycle sample sees old contents.
  always_ff @(posedge i_clk) begin
    if (i_sclr) begin
      r_shadow <= INIT_MASK;
      r_active <= INIT_MASK;
      r_look   <= 1'b0;
    end else begin
      if (i_shadow_we) r_shadow <= i_shadow_data;
      if (i_swap)      r_active <= r_shadow;
      if (i_din_valid) r_look   <= r_active[i_addr];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic r_out;
      always_ff @(posedge i_clk) begin
        if (i_sclr)        r_out <= 1'b0;
        else if (i_vld_s1) r_out <= r_look;
      end
      assign w_dout = r_out;
    end else begin : g_noreg
      assign w_dout = r_look;
    end
  endgenerate

  assign o_dout = CHIP_OK ? w_dout : 1'b0;
endmodule

// File: rtl/wys_lut_bank.sv
// Bank of 6-input LUT lanes with 16-bit beat mask loading and atomic all-lane commit.
module wys_lut_bank
  import wys_lut_pkg::*;
#(
  parameter int          LANES       = 4,
  parameter logic [63:0] INIT_MASK   = MASK_XOR6,
  parameter int          TARGET_CHIP = 1,
  parameter int          OUT_REG     = 1,
  localparam int         LW          = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               i_clk,
  input  logic               i_sclr,
  input  logic               i_din_valid,
  input  logic [6*LANES-1:0] i_din,
  output logic               o_dout_valid,
  output logic [LANES-1:0]   o_dout,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [LW-1:0]      i_cfg_lane,
  input  logic [15:0]        i_cfg_data,
  input  logic               i_cfg_commit,
  output logic               o_cfg_err,
  output logic [7:0]         o_cfg_gen
);
  localparam int STAGES  = (OUT_REG != 0) ? 2 : 1;
  localparam bit CHIP_OK = (TARGET_CHIP >= 0) && (TARGET_CHIP <= 2);

  cfg_state_e       r_state;
  logic [1:0]       r_beat;
  logic [LW-1:0]    r_lane;
  logic [47:0]      r_staging;
  logic             r_ready;
  logic             r_err;
  logic [7:0]       r_gen;
  logic [STAGES:1]  r_vld;

  logic             w_beat, w_commit, w_same, w_done, w_swap, w_bad_lane;
  logic [LANES-1:0] w_lane_hit, w_we;
  logic [63:0]      w_wr_data;

  assign w_beat     = i_cfg_valid & r_ready;
  assign w_commit   = i_cfg_commit & r_ready;
  assign w_same     = (r_state == S_LOAD) && (i_cfg_lane == r_lane);
  assign w_done     = w_beat && w_same && (r_beat == 2'd3);
  assign w_swap     = (r_state == S_SWAP);
  assign w_bad_lane = w_beat && !(|w_lane_hit);
  // Slices 0..2 are staged; the final slice goes straight from the port into shadow.
  assign w_wr_data  = {i_cfg_data, r_staging};

  always_ff @(posedge i_clk) begin
    if (i_sclr) begin
      r_state   <= S_IDLE;
      r_beat    <= 2'd0;
      r_lane    <= '0;
      r_staging <= '0;
      r_ready   <= 1'b1;
      r_err     <= 1'b0;
      r_gen     <= 8'd0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_beat) begin
            r_staging[15:0] <= i_cfg_data;
            r_lane          <= i_cfg_lane;
            r_beat          <= 2'd1;
            r_state         <= S_LOAD;
            r_err           <= w_commit | w_bad_lane;
          end else if (w_commit) begin
            r_state <= S_SWAP;
            r_ready <= 1'b0;
          end
        end
        S_LOAD: begin
          r_err <= w_commit | w_bad_lane | (w_beat & ~w_same);
          if (w_beat) begin
            if (!w_same) begin
              r_staging[15:0] <= i_cfg_data;
              r_lane          <= i_cfg_lane;
              r_beat          <= 2'd1;
            end else begin
              case (r_beat)
                2'd1:    r_staging[31:16] <= i_cfg_data;
                2'd2:    r_staging[47:32] <= i_cfg_data;
                default: r_state          <= S_IDLE;
              endcase
              r_beat <= r_beat + 2'd1;
            end
          end
        end
        S_SWAP: begin
          r_gen   <= r_gen + 8'd1;
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sclr) r_vld <= '0;
    else begin
      r_vld[1] <= i_din_valid;
      for (int k = 2; k <= STAGES; k++) r_vld[k] <= r_vld[k-1];
    end
  end

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign w_lane_hit[g] = (i_cfg_lane == LW'(g));
      assign w_we[g]       = w_done && (r_lane == LW'(g));
      wys_lut_lane #(
        .INIT_MASK (INIT_MASK),
        .OUT_REG   (OUT_REG),
        .CHIP_OK   (CHIP_OK)
      ) u_lane (
        .i_clk         (i_clk),
        .i_sclr        (i_sclr),
        .i_din_valid   (i_din_valid),
        .i_vld_s1      (r_vld[1]),
        .i_addr        (i_din[6*g +: 6]),
        .i_shadow_we   (w_we[g]),
        .i_shadow_data (w_wr_data),
        .i_swap        (w_swap),
        .o_dout        (o_dout[g])
      );
    end
  endgenerate

  assign o_dout_valid = r_vld[STAGES];
  assign o_cfg_ready  = r_ready;
  assign o_cfg_err    = r_err;
  assign o_cfg_gen    = r_gen;
endmodule

// File: tb/tb_wys_lut_bank.sv
// Self-checking bench for wys_lut_bank: constant vectors, corner sequences, random vs model.
module tb_wys_lut_bank;
  localparam int          LANES = 4;
  localparam int          L     = 2;
  localparam logic [63:0] XOR6  = 64'h6996966996696996;
  localparam logic [63:0] EQ3   = 64'h8040201008040201;

  logic        clk = 1'b0;
  logic        sclr, din_valid, cfg_valid, cfg_commit;
  logic [23:0] din;
  logic [1:0]  cfg_lane;
  logic [15:0] cfg_data;
  logic        dout_valid, cfg_ready, cfg_err;
  logic [3:0]  dout;
  logic [7:0]  cfg_gen;

  always #5 clk = ~clk;

  wys_lut_bank #(.LANES(LANES), .INIT_MASK(XOR6), .TARGET_CHIP(1), .OUT_REG(1)) dut (
    .i_clk(clk), .i_sclr(sclr), .i_din_valid(din_valid), .i_din(din),
    .o_dout_valid(dout_valid), .o_dout(dout), .i_cfg_valid(cfg_valid),
    .o_cfg_ready(cfg_ready), .i_cfg_lane(cfg_lane), .i_cfg_data(cfg_data),
    .i_cfg_commit(cfg_commit), .o_cfg_err(cfg_err), .o_cfg_gen(cfg_gen)
  );

  int total = 0, bad = 0;

  // Reference model: masks as plain arrays, output delay as a queue of samples.
  logic [63:0] m_shadow [LANES];
  logic [63:0] m_active [LANES];
  logic [15:0] m_stage [4];
  int          m_cnt, m_lane, m_gen;
  bit          m_loading, m_swapping, m_err;
  logic [3:0]  m_last;
  bit          q_v [$];
  logic [3:0]  q_d [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_shadow[i] = XOR6;
      m_active[i] = XOR6;
    end
    m_loading = 0; m_swapping = 0; m_err = 0; m_gen = 0; m_cnt = 0; m_lane = 0;
    m_last = 0;
    q_v.delete(); q_d.delete();
    for (int i = 0; i < L; i++) begin
      q_v.push_back(1'b0);
      q_d.push_back(4'd0);
    end
  endtask

  task automatic model_step();
    logic [3:0] r;
    if (sclr) begin
      model_reset();
      return;
    end
    if (din_valid) begin
      for (int i = 0; i < LANES; i++) r[i] = m_active[i][din[6*i +: 6]];
      m_last = r;
    end
    q_v.push_back(din_valid);
    q_d.push_back(m_last);
    if (q_v.size() > L) begin
      void'(q_v.pop_front());
      void'(q_d.pop_front());
    end
    m_err = 0;
    if (m_swapping) begin
      for (int i = 0; i < LANES; i++) m_active[i] = m_shadow[i];
      m_gen = (m_gen + 1) % 256;
      m_swapping = 0;
    end else begin
      if (cfg_commit && (m_loading || cfg_valid)) m_err = 1;
      if (cfg_valid) begin
        if (m_loading && int'(cfg_lane) != m_lane) m_err = 1;
        if (!m_loading || int'(cfg_lane) != m_lane) begin
          m_lane = int'(cfg_lane);
          m_stage[0] = cfg_data;
          m_cnt = 1;
          m_loading = 1;
        end else begin
          m_stage[m_cnt] = cfg_data;
          m_cnt++;
          if (m_cnt == 4) begin
            m_shadow[m_lane] = {m_stage[3], m_stage[2], m_stage[1], m_stage[0]};
            m_loading = 0;
          end
        end
      end else if (cfg_commit && !m_loading) begin
        m_swapping = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("dout", dout, q_d[0]);
    chk("dout_valid", dout_valid, q_v[0]);
    chk("cfg_err", cfg_err, m_err);
    chk("cfg_gen", cfg_gen, m_gen[7:0]);
    chk("cfg_ready", cfg_ready, !m_swapping);
  endtask

  task automatic beat(input logic [1:0] ln, input logic [15:0] d);
    cfg_valid = 1; cfg_lane = ln; cfg_data = d;
    tick();
    cfg_valid = 0;
  endtask

  task automatic load(input logic [1:0] ln, input logic [63:0] m);
    for (int k = 0; k < 4; k++) beat(ln, m[16*k +: 16]);
  endtask

  task automatic commit();
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    tick();
  endtask

  typedef struct { logic [23:0] din; logic [3:0] exp; } vec_t;
  vec_t tbl [4];

  initial begin
    sclr = 1; din_valid = 0; din = '0; cfg_valid = 0; cfg_commit = 0;
    cfg_lane = '0; cfg_data = '0;
    model_reset();
    tbl[0] = '{{6'h3F, 6'h00, 6'h03, 6'h01}, 4'b0001};
    tbl[1] = '{{6'h15, 6'h3E, 6'h00, 6'h07}, 4'b1101};
    tbl[2] = '{{6'h04, 6'h02, 6'h01, 6'h2A}, 4'b1111};
    tbl[3] = '{{6'h3F, 6'h3F, 6'h3F, 6'h3F}, 4'b0000};

    tick(); tick();
    sclr = 0;
    chk("rst_dout", dout, 4'd0);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_gen", cfg_gen, 8'd0);

    // Constant vectors against the xor6 reset masks; dout must hold afterwards.
    foreach (tbl[i]) begin
      din = tbl[i].din; din_valid = 1;
      tick();
      din_valid = 0; din = 24'($urandom);
      tick();
      chk("tbl_dout", dout, tbl[i].exp);
      chk("tbl_valid", dout_valid, 1'b1);
      tick();
      chk("tbl_hold", dout, tbl[i].exp);
      chk("tbl_vdrop", dout_valid, 1'b0);
    end

    // Load lane2 with eq3, commit while streaming across the swap.
    load(2'd2, EQ3);
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    chk("swap_ready", cfg_ready, 1'b0);
    din = {6'h00, 6'h2D, 6'h00, 6'h00}; din_valid = 1;
    tick();
    tick();
    din_valid = 0;
    chk("swap_old", dout[2], 1'b0);
    chk("swap_oldv", dout_valid, 1'b1);
    tick();
    chk("swap_new", dout[2], 1'b1);
    chk("swap_newv", dout_valid, 1'b1);
    chk("gen1", cfg_gen, 8'd1);

    // Lane change mid-load restarts on the new lane.
    beat(2'd1, 16'hAAAA);
    beat(2'd1, 16'h5555);
    beat(2'd3, EQ3[15:0]);
    chk("lane_sw_err", cfg_err, 1'b1);
    beat(2'd3, EQ3[31:16]);
    chk("err_1cyc", cfg_err, 1'b0);
    beat(2'd3, EQ3[47:32]);
    beat(2'd3, EQ3[63:48]);
    commit();
    din = {6'h09, 6'h2D, 6'h01, 6'h00}; din_valid = 1;
    tick();
    din_valid = 0;
    tick();
    chk("lane_sw_dout", dout, 4'b1110);

    // Commit during a load is rejected; beat+commit in idle too.
    beat(2'd0, 16'h1234);
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    chk("cmt_load_err", cfg_err, 1'b1);
    chk("cmt_load_gen", cfg_gen, 8'd2);
    beat(2'd0, 16'h1111); beat(2'd0, 16'h2222); beat(2'd0, 16'h3333);
    cfg_commit = 1;
    beat(2'd0, 16'h4444);
    cfg_commit = 0;
    chk("beat_cmt_err", cfg_err, 1'b1);
    chk("beat_cmt_ready", cfg_ready, 1'b1);
    beat(2'd0, 16'h5555); beat(2'd0, 16'h6666); beat(2'd0, 16'h7777);

    // Generation counter wrap.
    sclr = 1; tick(); sclr = 0;
    for (int i = 0; i < 256; i++) begin
      commit();
      if (i == 254) chk("gen255", cfg_gen, 8'd255);
    end
    chk("gen_wrap", cfg_gen, 8'd0);

    // sclr in the middle of a load and during the swap cycle.
    din = tbl[0].din; din_valid = 1;
    beat(2'd2, EQ3[15:0]);
    beat(2'd2, EQ3[31:16]);
    sclr = 1; tick(); sclr = 0; din_valid = 0;
    chk("sclr_load_dout", dout, 4'd0);
    chk("sclr_load_valid", dout_valid, 1'b0);
    chk("sclr_load_ready", cfg_ready, 1'b1);
    load(2'd2, EQ3);
    cfg_commit = 1; tick(); cfg_commit = 0;
    sclr = 1; tick(); sclr = 0;
    chk("sclr_swap_gen", cfg_gen, 8'd0);
    chk("sclr_swap_ready", cfg_ready, 1'b1);
    commit();
    din = {6'h00, 6'h2D, 6'h00, 6'h00}; din_valid = 1;
    tick();
    din_valid = 0;
    tick();
    chk("sclr_init_mask", dout[2], 1'b0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cfg_valid  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) cfg_lane = 2'($urandom);
      cfg_data   = 16'($urandom);
      cfg_commit = ($urandom_range(0, 9) == 0);
      din        = 24'($urandom);
      din_valid  = ($urandom_range(0, 3) != 0);
      sclr       = ($urandom_range(0, 299) == 0);
      tick();
    end
    sclr = 0; cfg_valid = 0; cfg_commit = 0; din_valid = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
